// File: rtl/video_scanout_if.sv
// video_scanout_if: VRAM read port and video-block pixel handshake of the scan-out controller
//   mem_req/mem_addr/mem_gnt : read issue (one read per cycle with req & gnt)
//   mem_rvalid/mem_rdata     : in-order read return, 24-bit {R,G,B}
//   pix_data/pix_en/pix_rdy  : pixel to video block, one pixel per rdy pulse
// master = scan-out controller, slave = memory/video side
interface video_scanout_if #(parameter int AW = 20);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [23:0]   mem_rdata;
  logic [23:0]   pix_data;
  logic          pix_en;
  logic          pix_rdy;
  modport master(output mem_req, mem_addr, pix_data, pix_en,
                 input mem_gnt, mem_rvalid, mem_rdata, pix_rdy);
  modport slave(input mem_req, mem_addr, pix_data, pix_en,
                output mem_gnt, mem_rvalid, mem_rdata, pix_rdy);
endinterface

// File: rtl/video_scanout.sv
// video_scanout: raster-order VRAM fetch into a pixel FIFO feeding the HDMI video block
//   clk, rst (sync, active-high)
//   enable     : run scan-out, sampled at frame boundaries
//   fb_base    : framebuffer base, latched at frame start
//   bus        : video_scanout_if.master (VRAM read port + pix_data/pix_en/pix_rdy)
//   frame_done : 1-cycle pulse once the last pixel of a frame has been handed off
//   underflow  : sticky, video asked for a pixel while the FIFO was empty
//   SCANOUT_TEST_PATTERN_EN adds input test_mode: colour-bar frames generated internally
module video_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int AW       = 20,
  parameter int STRIDE   = 1024,
  parameter int DEPTH    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [AW-1:0] fb_base,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic          test_mode,
`endif
  video_scanout_if.master bus,
  output logic          frame_done,
  output logic          underflow
);
  localparam int CW = $clog2(H_ACTIVE);
  localparam int RW = $clog2(V_ACTIVE);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);
  localparam logic [NW-1:0] FULL = NW'(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] line_addr;
  logic [NW-1:0] outstanding, count;
  logic [PW-1:0] wp, rp;
  logic [23:0]   mem [DEPTH];
  logic [NW:0]   used;
  logic          tp, issue, push_mem, push_tp, push, pop, advance;
  logic          col_last, row_last, drained, start;
  logic [23:0]   pat;
`ifdef SCANOUT_TEST_PATTERN_EN
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [2:0] bar;
  assign bar = 3'(col / CW'(H_ACTIVE / 8));
  assign pat = BARS[bar];
  always_ff @(posedge clk) tp <= rst ? 1'b0 : start ? test_mode : tp;
`else
  assign pat = '0;
  assign tp  = 1'b0;
`endif
  // credit: never have more reads in flight than free FIFO slots
  assign used     = {1'b0, outstanding} + {1'b0, count};
  assign bus.mem_req  = state == FETCH && !tp && used < (NW+1)'(DEPTH);
  assign bus.mem_addr = line_addr + AW'(col);
  assign issue    = bus.mem_req && bus.mem_gnt;
  // returns with nothing outstanding are stale (issued before a reset) and dropped
  assign push_mem = bus.mem_rvalid && outstanding != '0;
  assign push_tp  = state == FETCH && tp && count != FULL;
  assign push     = push_mem || push_tp;
  // a pop shows up as pix_en next cycle; blocking while pix_en is high keeps strobes apart
  assign pop      = bus.pix_rdy && count != '0 && !bus.pix_en;
  assign advance  = issue || push_tp;
  assign col_last = col == COL_LAST;
  assign row_last = row == ROW_LAST;
  assign drained  = outstanding == '0 && count == '0;
  assign start    = enable && (state == IDLE || (state == DRAIN && drained));
  always_ff @(posedge clk) if (push) mem[wp] <= push_tp ? pat : bus.mem_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      line_addr    <= '0;
      outstanding  <= '0;
      count        <= '0;
      wp           <= '0;
      rp           <= '0;
      bus.pix_en   <= 1'b0;
      bus.pix_data <= '0;
      frame_done   <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      assert (!(push && count == FULL));
      frame_done  <= 1'b0;
      bus.pix_en  <= pop;
      if (pop) begin
        bus.pix_data <= mem[rp];
        rp           <= rp + 1'b1;
      end
      if (push) wp <= wp + 1'b1;
      count       <= count + NW'(push) - NW'(pop);
      outstanding <= outstanding + NW'(issue) - NW'(push_mem);
      if (bus.pix_rdy && count == '0 && state != IDLE) underflow <= 1'b1;
      if (advance) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) begin
          row       <= row + 1'b1;
          line_addr <= line_addr + AW'(STRIDE);
        end
      end
      if (state == FETCH && advance && col_last && row_last) state <= DRAIN;
      if (state == DRAIN && drained) begin
        frame_done <= 1'b1;
        state      <= IDLE;
      end
      if (start) begin
        state     <= FETCH;
        line_addr <= fb_base;
        col       <= '0;
        row       <= '0;
        underflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout: scoreboard bench for video_scanout with a random-latency in-order VRAM model
module tb_video_scanout;
  localparam int H = 16, V = 4, AW = 20, STRIDE = 1024, DEPTH = 8;
  typedef struct {int due; logic [23:0] d;} ret_t;
  logic clk = 0, rst = 1, enable = 0;
  logic [AW-1:0] fb_base = '0;
`ifdef SCANOUT_TEST_PATTERN_EN
  logic test_mode = 0;
`endif
  logic frame_done, underflow;
  video_scanout_if #(.AW(AW)) bus();
  video_scanout #(.H_ACTIVE(H), .V_ACTIVE(V), .AW(AW), .STRIDE(STRIDE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fb_base(fb_base),
`ifdef SCANOUT_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .bus(bus.master), .frame_done(frame_done), .underflow(underflow));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int gnt_mode = 0, lat_lo = 1, lat_hi = 1, rdy_per = 0, rdy_once = 0;
  int cyc = 0, inflight = 0, fd_cnt = 0, pix_cnt = 0, grant_cnt = 0, last_due = 0;
  int exp_col = 0, exp_row = 0;
  logic prev_en = 0;
  logic [AW-1:0] exp_base = '0, first_addr = '0;
  logic [23:0] exp_q[$];
  ret_t ret_q[$];
  function automatic logic [23:0] pix_of(logic [AW-1:0] a);
    return {a[11:0], a[19:8]} ^ 24'h5A5A5A;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [23:0] e;
    logic [AW-1:0] ea;
    int k, due;
    ret_t r;
    #1;
    if (bus.pix_en) begin
      pix_cnt++;
      inflight--;
      checks++;
      assert (!prev_en) else begin errors++; $error("FAIL pix_en_gap: observed two consecutive strobes, expected a gap"); end
      checks++;
      assert (exp_q.size() != 0) else begin errors++; $error("FAIL pix_unexpected: observed %h expected no pixel", bus.pix_data); end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (bus.pix_data === e) else begin errors++; $error("FAIL pix_data: observed %h expected %h", bus.pix_data, e); end
      end
    end
    prev_en = bus.pix_en;
    if (frame_done) fd_cnt++;
    checks++;
    assert (inflight <= DEPTH) else begin errors++; $error("FAIL fifo_credit: observed %0d expected <= %0d", inflight, DEPTH); end
    k = cyc + 1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    if (ret_q.size() != 0 && ret_q[0].due <= k) begin
      r = ret_q.pop_front();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = r.d;
    end
    bus.mem_gnt = gnt_mode == 1 || (gnt_mode == 2 && $urandom_range(0, 1) == 1);
    bus.pix_rdy = (rdy_per != 0 && k % rdy_per == 0) || rdy_once != 0;
    rdy_once = 0;
    if (bus.mem_req && bus.mem_gnt && !rst) begin
      if (exp_col == 0 && exp_row == 0) begin
        exp_base = fb_base;
        first_addr = bus.mem_addr;
      end
      ea = exp_base + AW'(exp_row * STRIDE + exp_col);
      checks++;
      assert (bus.mem_addr === ea) else begin errors++; $error("FAIL mem_addr: observed %h expected %h", bus.mem_addr, ea); end
      exp_q.push_back(pix_of(ea));
      due = k + int'($urandom_range(lat_lo, lat_hi));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      ret_q.push_back('{due, pix_of(bus.mem_addr)});
      inflight++;
      grant_cnt++;
      exp_col++;
      if (exp_col == H) begin
        exp_col = 0;
        exp_row++;
        if (exp_row == V) exp_row = 0;
      end
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask
  task automatic wait_req(string tag);
    int n = 0;
    while (!bus.mem_req && n < 300) begin tick(); n++; end
    chk({tag, "_req_seen"}, 32'(bus.mem_req), 32'd1);
  endtask
  task automatic wait_done(string tag);
    int n = 0, f0 = fd_cnt;
    while (fd_cnt == f0 && n < 4000) begin tick(); n++; end
    chk({tag, "_frame_done"}, 32'(fd_cnt - f0), 32'd1);
  endtask
  task automatic wait_row(string tag, int r);
    int n = 0;
    while (exp_row != r && n < 2000) begin tick(); n++; end
    chk({tag, "_row_reached"}, 32'(exp_row), 32'(r));
  endtask
  task automatic req_quiet(string tag);
    logic seen = 0;
    repeat (20) begin tick(); seen |= bus.mem_req; end
    chk({tag, "_req_quiet"}, 32'(seen), 32'd0);
  endtask
  initial begin
    int p0, f0, n;
    tick(3);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_pix_en", 32'(bus.pix_en), 32'd0);
    chk("rst_pix_data", 32'(bus.pix_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    rst = 0;
    tick(2);
    chk("idle_no_req", 32'(bus.mem_req), 32'd0);
    // one frame, 1-cycle memory, base 0x1000
    p0 = pix_cnt; f0 = fd_cnt;
    fb_base = 20'h01000; gnt_mode = 1; lat_lo = 1; lat_hi = 1; rdy_per = 2; enable = 1;
    wait_req("t1");
    chk("t1_first_addr", 32'(bus.mem_addr), 32'h1000);
    enable = 0;
    n = 0;
    while (!(bus.mem_req && grant_cnt == H) && n < 300) begin tick(); n++; end
    chk("t1_line1_addr", 32'(bus.mem_addr), 32'h1400);
    wait_done("t1");
    tick(2);
    chk("t1_pixels", 32'(pix_cnt - p0), 32'(H * V));
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    req_quiet("t1");
    chk("t1_done_once", 32'(fd_cnt - f0), 32'd1);
    // fill to credit limit, single rdy pulse, then random grant/latency
    p0 = pix_cnt;
    rdy_per = 0; enable = 1;
    wait_req("t2");
    enable = 0;
    tick(30);
    chk("t2_credit_stall", 32'(bus.mem_req), 32'd0);
    chk("t2_fifo_full", 32'(inflight), 32'(DEPTH));
    rdy_once = 1;
    tick();
    chk("t2_rdy_to_en", 32'(bus.pix_en), 32'd1);
    chk("t2_credit_free", 32'(bus.mem_req), 32'd1);
    tick();
    chk("t2_en_single", 32'(bus.pix_en), 32'd0);
    chk("t2_credit_restall", 32'(bus.mem_req), 32'd0);
    gnt_mode = 2; lat_lo = 1; lat_hi = 6; rdy_per = 8;
    wait_done("t2");
    tick(2);
    chk("t2_pixels", 32'(pix_cnt - p0), 32'(H * V));
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    // underflow: no grants while video pulses rdy
    gnt_mode = 0; rdy_per = 2; enable = 1;
    tick(20);
    chk("t3_uf_set", 32'(underflow), 32'd1);
    enable = 0; gnt_mode = 1;
    tick(30);
    chk("t3_uf_sticky", 32'(underflow), 32'd1);
    wait_done("t3");
    tick(5);
    chk("t3_uf_idle", 32'(underflow), 32'd1);
    // next frame start clears underflow; base change mid-frame, enable drop at row 2 of the next
    p0 = pix_cnt;
    rdy_per = 0; fb_base = 20'h01000; enable = 1;
    tick();
    chk("t4_uf_clear", 32'(underflow), 32'd0);
    gnt_mode = 2; rdy_per = 8;
    wait_row("t4", 2);
    fb_base = 20'h08000;
    wait_done("t4a");
    wait_row("t5", 2);
    chk("t5_next_base", 32'(first_addr), 32'h8000);
    enable = 0;
    wait_done("t5");
    tick(2);
    chk("t5_pixels", 32'(pix_cnt - p0), 32'(2 * H * V));
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    req_quiet("t5");
    // reset with reads in flight
    rdy_per = 0; gnt_mode = 1; lat_lo = 6; lat_hi = 6; fb_base = 20'h02000; enable = 1;
    n = 0;
    while (ret_q.size() < 3 && n < 100) begin tick(); n++; end
    chk("t6_outstanding", 32'(ret_q.size() >= 3), 32'd1);
    rst = 1; enable = 0;
    tick();
    rst = 0;
    exp_q.delete(); exp_col = 0; exp_row = 0; inflight = 0; prev_en = 0;
    chk("t6_rst_req", 32'(bus.mem_req), 32'd0);
    chk("t6_rst_uf", 32'(underflow), 32'd0);
    p0 = pix_cnt;
    tick(12);
    chk("t6_late_done", 32'(ret_q.size()), 32'd0);
    chk("t6_no_pix", 32'(pix_cnt - p0), 32'd0);
    gnt_mode = 2; lat_lo = 1; lat_hi = 6; rdy_per = 2; enable = 1;
    wait_req("t6");
    chk("t6_restart_addr", 32'(bus.mem_addr), 32'h2000);
    enable = 0;
    wait_done("t6");
    tick(2);
    chk("t6_pixels", 32'(pix_cnt - p0), 32'(H * V));
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
